// File: rtl/photon_ctrl.sv
// PHOTON-224 sponge-state register file and permutation sequencer; READ/CHECK data is combinational.
// HASH-to-ready takes 3+ cycles; stalls are absorbed by the hash_armed edge detect, busy is reported as !ready.
module photon_ctrl #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 8,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      Rst,
    input  logic [2:0]                opcode,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         data_in,
    output logic [DATA_W-1:0]         data_out,
    output logic                      ready,
    output logic                      err,
    output logic                      perm_start,
    output logic [NREGS*DATA_W-1:0]   perm_state_out,
    input  logic [NREGS*DATA_W-1:0]   perm_state_in,
    input  logic                      perm_done
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_HASH  = 3'd3;
    localparam logic [2:0] OP_CHECK = 3'd4;

    // Last WAIT count before abort: WAIT lasts at most TIMEOUT cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              hash_armed_q;
    logic              err_q, err_d;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic is_read, is_write, is_hash, is_check, is_none;
    logic hash_accept, timeout_hit, wb_en, wr_en, err_event;

    assign is_none  = (opcode == OP_NONE);
    assign is_read  = (opcode == OP_READ);
    assign is_write = (opcode == OP_WRITE);
    assign is_hash  = (opcode == OP_HASH);
    assign is_check = (opcode == OP_CHECK);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        perm_start  = 1'b0;
        hash_accept = 1'b0;
        timeout_hit = 1'b0;
        wb_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (is_hash && hash_armed_q) begin
                    hash_accept = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                perm_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A done coinciding with the final count still wins.
                if (perm_done) begin
                    wb_en   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready = (state_q == S_IDLE);
    assign err   = err_q;
    assign wr_en = is_write && ready;

    // Only an armed HASH counts as a busy violation; stalled repeats are silent.
    assign err_event = (is_hash && hash_armed_q && !ready)
                     || (is_write && !ready)
                     || timeout_hit;

    always_comb begin
        err_d = err_q;
        if (err_event)
            err_d = 1'b1;
        else if (is_check)
            err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hash_armed_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hash_armed_q <= !is_hash;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (wb_en) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= perm_state_in[i*DATA_W +: DATA_W];
        end else if (wr_en) begin
            regs_q[addr] <= data_in;
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++)
            perm_state_out[i*DATA_W +: DATA_W] = regs_q[i];
    end

    always_comb begin
        data_out = '0;
        if (is_read) begin
            data_out = regs_q[addr];
        end else if (is_check) begin
            data_out[1] = err_q;
            data_out[0] = ready;
        end else if (is_none || is_write || is_hash) begin
            data_out = '0;
        end
    end

endmodule

// File: tb/tb_photon_ctrl.sv
// Scoreboard bench for photon_ctrl: two instances (TIMEOUT 255 with a responding permutation core,
// TIMEOUT 4 with perm_done tied low) share one stimulus stream and are checked against a transaction model.
module tb_photon_ctrl;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_HASH  = 3'd3;
    localparam logic [2:0] OP_CHECK = 3'd4;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         Rst;
    logic [2:0]   opcode;
    logic [2:0]   addr;
    logic [31:0]  data_in;
    logic [255:0] pin;
    logic         done;
    logic [255:0] pin_b;
    logic         done_b;

    logic [31:0]  dout_a, dout_b;
    logic         rdy_a, rdy_b, err_a, err_b, ps_a, ps_b;
    logic [255:0] pso_a, pso_b;

    photon_ctrl #(.DATA_W(32), .NREGS(8), .ADDR_W(3), .TIMEOUT(255)) dut_a (
        .clk(clk), .Rst(Rst), .opcode(opcode), .addr(addr), .data_in(data_in),
        .data_out(dout_a), .ready(rdy_a), .err(err_a), .perm_start(ps_a),
        .perm_state_out(pso_a), .perm_state_in(pin), .perm_done(done));

    photon_ctrl #(.DATA_W(32), .NREGS(8), .ADDR_W(3), .TIMEOUT(4)) dut_b (
        .clk(clk), .Rst(Rst), .opcode(opcode), .addr(addr), .data_in(data_in),
        .data_out(dout_b), .ready(rdy_b), .err(err_b), .perm_start(ps_b),
        .perm_state_out(pso_b), .perm_state_in(pin_b), .perm_done(done_b));

    // Model state: busy_age counts cycles since HASH acceptance (1 = launch cycle).
    typedef struct {
        logic [7:0][31:0] r;
        bit               busy;
        int               busy_age;
        bit               armed;
        bit               err;
        int               to;
    } mdl_t;

    typedef struct {
        logic [31:0]  dout;
        bit           rdy;
        bit           er;
        bit           ps;
        logic [255:0] pso;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
    } exp2_t;

    exp2_t q[$];
    mdl_t  ma, mb;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc = 0;
    int    done_at = -1;
    int    lat = 5;
    bit    spur_en = 0;
    int    n_starts_exp = 0;
    int    n_starts_obs = 0;
    logic [255:0] done_val;

    function automatic exp_t m_out(mdl_t m, logic [2:0] op, int ad);
        exp_t e;
        e.rdy  = !m.busy;
        e.er   = m.err;
        e.ps   = m.busy && (m.busy_age == 1);
        e.pso  = m.r;
        e.dout = 32'h0;
        if (op == OP_READ)
            e.dout = m.r[ad];
        else if (op == OP_CHECK)
            e.dout = {30'b0, m.err, !m.busy};
        return e;
    endfunction

    function automatic mdl_t m_step(mdl_t m, logic [2:0] op, int ad, logic [31:0] d,
                                    bit dn, logic [255:0] p, bit rst);
        mdl_t n;
        bit   ev;
        n  = m;
        ev = 0;
        if (!rst) begin
            n.r = '0; n.busy = 0; n.busy_age = 0; n.armed = 1; n.err = 0;
            return n;
        end
        if (m.busy) begin
            if (op == OP_HASH && m.armed) ev = 1;
            if (op == OP_WRITE) ev = 1;
            if (m.busy_age >= 2) begin
                if (dn) begin
                    n.r = p; n.busy = 0;
                end else if (m.busy_age - 1 == m.to) begin
                    n.busy = 0; ev = 1;
                end else begin
                    n.busy_age = m.busy_age + 1;
                end
            end else begin
                n.busy_age = 2;
            end
        end else begin
            if (op == OP_WRITE) n.r[ad] = d;
            if (op == OP_HASH && m.armed) begin
                n.busy = 1; n.busy_age = 1;
            end
        end
        if (ev) n.err = 1;
        else if (op == OP_CHECK) n.err = 0;
        n.armed = (op != OP_HASH);
        return n;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the expected outputs for it are queued for the monitor.
    task automatic step(input logic [2:0] op, input logic [2:0] ad, input logic [31:0] d,
                        input bit rst = 1'b1);
        exp2_t e;
        bit    dn;
        opcode  = op;
        addr    = ad;
        data_in = d;
        Rst     = rst;
        dn = (cyc == done_at);
        if (!dn && spur_en && !(ma.busy && ma.busy_age >= 2) && $urandom_range(0, 15) == 0)
            dn = 1;
        done = dn;
        pin  = (cyc == done_at) ? done_val
             : {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        e.a = m_out(ma, op, int'(ad));
        e.b = m_out(mb, op, int'(ad));
        q.push_back(e);
        if (e.a.ps) begin
            done_at  = cyc + lat;
            done_val = ~ma.r;
            n_starts_exp++;
        end
        @(posedge clk);
        ma = m_step(ma, op, int'(ad), d, dn, pin, rst);
        mb = m_step(mb, op, int'(ad), d, 1'b0, '0, rst);
        cyc++;
        #1;
    endtask

    always @(negedge clk) begin
        exp2_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("a.data_out",   {224'b0, dout_a}, {224'b0, e.a.dout});
            chk("a.ready",      {255'b0, rdy_a},  {255'b0, e.a.rdy});
            chk("a.err",        {255'b0, err_a},  {255'b0, e.a.er});
            chk("a.perm_start", {255'b0, ps_a},   {255'b0, e.a.ps});
            chk("a.state_out",  pso_a,            e.a.pso);
            chk("b.data_out",   {224'b0, dout_b}, {224'b0, e.b.dout});
            chk("b.ready",      {255'b0, rdy_b},  {255'b0, e.b.rdy});
            chk("b.err",        {255'b0, err_b},  {255'b0, e.b.er});
            chk("b.perm_start", {255'b0, ps_b},   {255'b0, e.b.ps});
            chk("b.state_out",  pso_b,            e.b.pso);
            if (ps_a === 1'b1) n_starts_obs++;
        end
    end

    initial begin
        Rst = 1'b0; opcode = OP_NONE; addr = '0; data_in = '0;
        pin = '0; done = 1'b0; pin_b = '0; done_b = 1'b0;
        ma.to = 255; mb.to = 4;
        repeat (2) @(posedge clk);
        #1;
        ma = m_step(ma, OP_NONE, 0, 0, 0, '0, 0);
        mb = m_step(mb, OP_NONE, 0, 0, 0, '0, 0);

        // Reset clears a written register; CHECK reads idle status.
        step(OP_WRITE, 3, 32'hDEADBEEF);
        step(OP_READ, 3, 0);
        step(OP_NONE, 0, 0, 1'b0);
        step(OP_READ, 3, 0);
        step(OP_CHECK, 0, 0);

        // Write/read and state packing.
        for (int i = 0; i < 8; i++) step(OP_WRITE, 3'(i), 32'h11111111 * (i + 1));
        for (int i = 0; i < 8; i++) step(OP_READ, 3'(i), 0);

        // Round trip: inverted state returned 5 cycles after launch.
        lat = 5;
        step(OP_HASH, 0, 0);
        for (int i = 0; i < 7; i++) step(OP_NONE, 0, 0);
        for (int i = 0; i < 8; i++) step(OP_READ, 3'(i), 0);
        step(OP_CHECK, 0, 0);
        step(OP_CHECK, 0, 0);

        // Stalled HASH held for 10 cycles.
        for (int i = 0; i < 10; i++) step(OP_HASH, 0, 0);
        step(OP_CHECK, 0, 0);
        for (int i = 0; i < 8; i++) step(OP_READ, 3'(i), 0);

        // Busy violation: WRITE during WAIT is dropped and flags err.
        lat = 8;
        step(OP_HASH, 0, 0);
        step(OP_NONE, 0, 0);
        step(OP_NONE, 0, 0);
        step(OP_WRITE, 1, 32'h5);
        step(OP_CHECK, 0, 0);
        for (int i = 0; i < 8; i++) step(OP_NONE, 0, 0);
        step(OP_CHECK, 0, 0);
        step(OP_READ, 1, 0);

        // Reset during WAIT, then a late perm_done.
        lat = 6;
        step(OP_HASH, 0, 0);
        step(OP_NONE, 0, 0);
        step(OP_NONE, 0, 0);
        step(OP_NONE, 0, 0, 1'b0);
        for (int i = 0; i < 6; i++) step(OP_NONE, 0, 0);
        for (int i = 0; i < 8; i++) step(OP_READ, 3'(i), 0);
        step(OP_CHECK, 0, 0);

        // Randomized traffic with varying permutation latency and spurious dones.
        spur_en = 1;
        for (int i = 0; i < 600; i++) begin
            int      sel;
            logic [2:0] op;
            sel = $urandom_range(0, 99);
            op  = (sel < 15) ? OP_NONE : (sel < 40) ? OP_READ : (sel < 65) ? OP_WRITE
                : (sel < 85) ? OP_HASH : OP_CHECK;
            lat = $urandom_range(1, 12);
            step(op, 3'($urandom_range(0, 7)), $urandom(), ($urandom_range(0, 99) != 0));
        end
        spur_en = 0;
        for (int i = 0; i < 20; i++) step(OP_NONE, 0, 0);

        @(negedge clk);
        #1;
        chk("perm_start_count", 256'(n_starts_obs), 256'(n_starts_exp));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
